// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. New BCD values are accepted through a one-deep pending
// slot and copied into the display register only when the scan wraps from
// digit 3 to digit 0. This means a frame never mixes old and new digits.
module seven_seg_scanner #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] bcd_in,
   input  logic        bcd_valid,
   output logic        bcd_ready,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic [3:0]  Dig,
   output logic        frame_done
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   // BCD to active-low segments {g,f,e,d,c,b,a}; non-BCD codes show a dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      disp_q, disp_d;
   logic [15:0]      pend_q, pend_d;
   logic             pend_full_q, pend_full_d;
   logic             bcd_ready_q, bcd_ready_d;
   logic             frame_done_q, frame_done_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       dig_q, dig_d;

   logic             tick;
   logic             wrap;
   logic             capture;
   logic [3:0]       cur_digit;
   logic             lz_blank;

   // Prescaler, digit index, pending slot and frame-boundary transfer.
   always_comb begin
      tick         = (cnt_q == CNT_MAX);
      wrap         = tick && (idx_q == 2'd3);
      capture      = bcd_valid && bcd_ready_q;
      cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d        = tick ? idx_q + 2'd1 : idx_q;
      frame_done_d = wrap;
      disp_d       = disp_q;
      pend_d       = pend_q;
      pend_full_d  = pend_full_q;
      // Capture only happens while the slot is empty, and transfer only while
      // it is full, so the two never occur on the same edge.
      if (wrap && pend_full_q) begin
         disp_d      = pend_q;
         pend_full_d = 1'b0;
      end else if (capture) begin
         pend_d      = bcd_in;
         pend_full_d = 1'b1;
      end
      bcd_ready_d = !pend_full_d;
   end

   // Digit selection, leading-zero blanking and the anti-ghosting blank window.
   always_comb begin
      cur_digit = disp_q[3:0];
      lz_blank  = 1'b0;
      case (idx_q)
         2'd0: cur_digit = disp_q[3:0];
         2'd1: begin
            cur_digit = disp_q[7:4];
            lz_blank  = (disp_q[15:4] == 12'h000);
         end
         2'd2: begin
            cur_digit = disp_q[11:8];
            lz_blank  = (disp_q[15:8] == 8'h00);
         end
         default: begin
            cur_digit = disp_q[15:12];
            lz_blank  = (disp_q[15:12] == 4'h0);
         end
      endcase
      seg_d = SEG_OFF;
      dig_d = 4'hF;
      if (cnt_q >= BLANK_END) begin
         dig_d = ~(4'b0001 << idx_q);
         seg_d = (blank_lz && lz_blank) ? SEG_OFF : decode(cur_digit);
      end
   end

   // State and output registers; asynchronous reset returns the display to dark.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         disp_q       <= 16'h0000;
         pend_q       <= 16'h0000;
         pend_full_q  <= 1'b0;
         bcd_ready_q  <= 1'b1;
         frame_done_q <= 1'b0;
         seg_q        <= SEG_OFF;
         dig_q        <= 4'hF;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pend_full_q  <= pend_full_d;
         bcd_ready_q  <= bcd_ready_d;
         frame_done_q <= frame_done_d;
         seg_q        <= seg_d;
         dig_q        <= dig_d;
      end
   end

   assign bcd_ready  = bcd_ready_q;
   assign frame_done = frame_done_q;
   assign seg        = seg_q;
   assign Dig        = dig_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with REFRESH_DIV=4, BLANK_CYCLES=1.
// Stimulus pushes the expected {Dig,seg} of each lit slot into a queue; a
// monitor branch pops and compares at the start of every lit slot.
module tb_seven_seg_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] bcd_in = 16'h0000;
   logic        bcd_valid = 1'b0;
   logic        blank_lz = 1'b0;
   logic        bcd_ready;
   logic [6:0]  seg;
   logic [3:0]  dig;
   logic        frame_done;

   int          n_pass = 0;
   int          n_tot = 0;
   logic [10:0] sb[$];
   bit          done = 1'b0;
   bit          len_en = 1'b0;
   logic [3:0]  prev_dig = 4'hF;
   int          run = 0;

   seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bcd_in     (bcd_in),
      .bcd_valid  (bcd_valid),
      .bcd_ready  (bcd_ready),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .Dig        (dig),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 100);
      if (!frame_done) chk("frame_timeout", frame_done, 1);
   endtask

   task automatic load(input logic [15:0] v);
      int n = 0;
      while (!bcd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_load", bcd_ready, 1);
      bcd_in    = v;
      bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      chk("ready_after_capture", bcd_ready, 0);
   endtask

   task automatic push4(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
      sb.push_back({4'hE, s0});
      sb.push_back({4'hD, s1});
      sb.push_back({4'hB, s2});
      sb.push_back({4'h7, s3});
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drain", sb.size(), 0);
   endtask

   initial begin
      fork
         begin : stim
            int n;
            // Reset held across edges
            rst_n = 1'b0;
            cyc(3);
            chk("rst_seg", seg, 7'h7F);
            chk("rst_dig", dig, 4'hF);
            chk("rst_ready", bcd_ready, 1);
            chk("rst_fd", frame_done, 0);
            sb.push_back({4'hE, 7'h40});
            rst_n = 1'b1;
            cyc(1);
            chk("post_rst_blank", dig, 4'hF);
            drain();

            // Scan of 1234 over two frames, slot length and frame period
            load(16'h1234);
            wait_frame();
            push4(7'h19, 7'h30, 7'h24, 7'h79);
            push4(7'h19, 7'h30, 7'h24, 7'h79);
            len_en = 1'b1;
            cyc(1);
            chk("fd_width", frame_done, 0);
            n = 1;
            while (!frame_done && n < 40) begin
               cyc(1);
               n++;
            end
            chk("fd_period", n, 16);
            drain();
            len_en = 1'b0;

            // Handshake: mid-frame load, old value until wrap, retry ignored
            wait_frame();
            push4(7'h19, 7'h30, 7'h24, 7'h79);
            push4(7'h00, 7'h78, 7'h02, 7'h12);
            cyc(6);
            load(16'h5678);
            bcd_in    = 16'h9999;
            bcd_valid = 1'b1;
            cyc(3);
            bcd_valid = 1'b0;
            chk("ready_held", bcd_ready, 0);
            wait_frame();
            chk("ready_after_xfer", bcd_ready, 1);
            push4(7'h00, 7'h78, 7'h02, 7'h12);
            drain();

            // Leading-zero blanking
            blank_lz = 1'b1;
            load(16'h0070);
            wait_frame();
            push4(7'h40, 7'h78, 7'h7F, 7'h7F);
            drain();
            blank_lz = 1'b0;
            wait_frame();
            push4(7'h40, 7'h78, 7'h40, 7'h40);
            drain();
            blank_lz = 1'b1;
            load(16'h0A05);
            wait_frame();
            push4(7'h12, 7'h40, 7'h3F, 7'h7F);
            drain();

            // Non-BCD digits show a dash
            blank_lz = 1'b0;
            load(16'hA9F0);
            wait_frame();
            push4(7'h40, 7'h3F, 7'h10, 7'h3F);
            drain();

            // Asynchronous reset mid-frame with a pending value
            wait_frame();
            cyc(3);
            load(16'h4321);
            cyc(2);
            #2 rst_n = 1'b0;
            #1;
            chk("arst_seg", seg, 7'h7F);
            chk("arst_dig", dig, 4'hF);
            chk("arst_ready", bcd_ready, 1);
            chk("arst_fd", frame_done, 0);
            @(negedge clk);
            cyc(2);
            chk("arst_ready_hold", bcd_ready, 1);
            rst_n = 1'b1;
            push4(7'h40, 7'h40, 7'h40, 7'h40);
            drain();
            wait_frame();
            push4(7'h40, 7'h40, 7'h40, 7'h40);
            drain();
            done = 1'b1;
         end
         begin : monitor
            while (!done) begin
               @(negedge clk);
               if (dig !== prev_dig) begin
                  if (len_en && prev_dig != 4'hF) chk("lit_len", run, 3);
                  if (dig != 4'hF && prev_dig == 4'hF && sb.size() > 0)
                     chk("slot", {dig, seg}, sb.pop_front());
                  run = 1;
               end else begin
                  run++;
               end
               prev_dig = dig;
            end
         end
      join
      chk("sb_empty_end", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
